// File: rtl/menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : menu_ctrl
// Purpose  : Front-end control for the VGA text renderer. Debounces the four
//            board push-buttons, runs the TITLE/MENU/GAME/CREDITS state
//            machine and generates the cursor blink from renderer frames.
// Ports    : clk, rst (sync, active-low)
//            btn_up/btn_down/btn_sel/btn_back : raw buttons, async, act-high
//            vs         : renderer vertical sync, active-low pulse per frame
//            game_over  : level from the game core
//            screen_sel : 0 TITLE, 1 MENU, 2 GAME, 3 CREDITS
//            cursor_idx : highlighted menu row
//            cursor_vis : cursor drawn when high
//            difficulty : 0 easy, 1 normal, 2 hard
//            game_start : one-clk pulse on entry to GAME
// Revision : 1.0 - initial release
// ============================================================================
module menu_ctrl #(
  parameter int DB_CYCLES    = 1000000,
  parameter int MENU_ITEMS   = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_back,
  input  logic       vs,
  input  logic       game_over,
  output logic [1:0] screen_sel,
  output logic [1:0] cursor_idx,
  output logic       cursor_vis,
  output logic [1:0] difficulty,
  output logic       game_start
);

  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DB_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [1:0]         CURSOR_MAX = 2'(MENU_ITEMS - 1);

  localparam logic [1:0] S_TITLE   = 2'd0;
  localparam logic [1:0] S_MENU    = 2'd1;
  localparam logic [1:0] S_GAME    = 2'd2;
  localparam logic [1:0] S_CREDITS = 2'd3;

  // Button order: 0 up, 1 down, 2 sel, 3 back.
  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btn_back, btn_sel, btn_down, btn_up};

  // --------------------------------------------------------------------------
  // Per-button synchroniser + debounce + press detection
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic            sync1;
    logic            sync2;
    logic            stable;
    logic            armed;
    logic [DB_W-1:0] cnt;

    // Synchroniser flops carry no reset so that they keep tracking the pad
    // while rst is held; this lets the armed flag below see a held button.
    always_ff @(posedge clk) begin
      sync1 <= btn_raw[i];
      sync2 <= sync1;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt    <= '0;
        stable <= 1'b0;
        armed  <= 1'b0;
      end else begin
        // A press only counts once the button has been seen released since
        // reset; a button held through reset re-qualifies silently.
        if (!sync2) armed <= 1'b1;
        if (sync2 == stable) begin
          cnt <= '0;
        end else if (cnt == DB_MAX) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Rising edge of the stable level, flagged in the clk it is accepted.
    assign press[i] = sync2 && !stable && (cnt == DB_MAX) && armed;
  end

  // --------------------------------------------------------------------------
  // Arbitration: sel > back > up > down, losers are dropped
  // --------------------------------------------------------------------------
  logic ev_sel, ev_back, ev_up, ev_down;

  assign ev_sel  = press[2];
  assign ev_back = press[3] && !press[2];
  assign ev_up   = press[0] && !press[2] && !press[3];
  assign ev_down = press[1] && !press[0] && !press[2] && !press[3];

  // --------------------------------------------------------------------------
  // Screen state machine (state register is screen_sel itself)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      screen_sel <= S_TITLE;
      cursor_idx <= 2'd0;
      difficulty <= 2'd1;
      game_start <= 1'b0;
    end else begin
      game_start <= 1'b0;
      case (screen_sel)
        S_TITLE: begin
          if (ev_sel) begin
            screen_sel <= S_MENU;
            cursor_idx <= 2'd0;
          end
        end
        S_MENU: begin
          if (ev_sel) begin
            if (cursor_idx == 2'd0) begin
              screen_sel <= S_GAME;
              game_start <= 1'b1;
            end else if (cursor_idx == 2'd1) begin
              difficulty <= (difficulty == 2'd2) ? 2'd0 : difficulty + 2'd1;
            end else begin
              screen_sel <= S_CREDITS;
            end
          end else if (ev_back) begin
            screen_sel <= S_TITLE;
          end else if (ev_up) begin
            cursor_idx <= (cursor_idx == 2'd0) ? CURSOR_MAX : cursor_idx - 2'd1;
          end else if (ev_down) begin
            cursor_idx <= (cursor_idx == CURSOR_MAX) ? 2'd0 : cursor_idx + 2'd1;
          end
        end
        S_GAME: begin
          if (game_over) begin
            screen_sel <= S_TITLE;
            cursor_idx <= 2'd0;
          end
        end
        default: begin
          if (ev_sel || ev_back) screen_sel <= S_MENU;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Cursor blink driven by falling edges of the synchronised vs
  // --------------------------------------------------------------------------
  logic               vs_s1, vs_s2, vs_s3;
  logic               frame_tick;
  logic               enter_menu, cursor_move, leave_menu;
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    vs_s1 <= vs;
    vs_s2 <= vs_s1;
    vs_s3 <= vs_s2;
  end

  assign frame_tick  = vs_s3 && !vs_s2;
  assign enter_menu  = ((screen_sel == S_TITLE) && ev_sel) ||
                       ((screen_sel == S_CREDITS) && (ev_sel || ev_back));
  assign cursor_move = (screen_sel == S_MENU) && (ev_up || ev_down);
  assign leave_menu  = (screen_sel == S_MENU) &&
                       ((ev_sel && (cursor_idx != 2'd1)) || ev_back);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cursor_vis <= 1'b0;
      blink_cnt  <= '0;
    end else if (enter_menu || cursor_move) begin
      cursor_vis <= 1'b1;
      blink_cnt  <= '0;
    end else if ((screen_sel != S_MENU) || leave_menu) begin
      cursor_vis <= 1'b0;
      blink_cnt  <= '0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt  <= '0;
        cursor_vis <= !cursor_vis;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/menu_ctrl.md
Name: menu_ctrl

Overview:
- Front-end control stage that sits directly upstream of the VGA text renderer.
- Debounces the board push-buttons and runs the title/menu/game/credits state machine.
- Drives the renderer's screen-select, cursor row and cursor blink inputs, plus the difficulty setting and a game-start pulse for the game core.
- Runs on the 100 MHz board clock; the renderer derives its pixel clock from the same clock.

Parameters:
- DB_CYCLES, 1000000, clk cycles a raw button must hold a new level before it is accepted (10 ms at 100 MHz).
- MENU_ITEMS, 3, number of menu rows: 0 START, 1 DIFFICULTY, 2 CREDITS.
- BLINK_FRAMES, 30, VGA frames per cursor blink half-period.

Ports:
- clk  in  1  board clock, 100 MHz.
- rst  in  1  reset; synchronous, active-low.
- btn_up  in  1  raw push-button, active-high, asynchronous to clk.
- btn_down  in  1  raw push-button, active-high, asynchronous to clk.
- btn_sel  in  1  raw push-button, active-high, asynchronous to clk.
- btn_back  in  1  raw push-button, active-high, asynchronous to clk.
- vs  in  1  vertical sync from the renderer, active-low pulse, one per frame.
- game_over  in  1  level from the game core, sampled each clk.
- screen_sel  out  2  0 TITLE, 1 MENU, 2 GAME, 3 CREDITS.
- cursor_idx  out  2  highlighted menu row, range 0..MENU_ITEMS-1.
- cursor_vis  out  1  cursor drawn when high.
- difficulty  out  2  0 easy, 1 normal, 2 hard.
- game_start  out  1  one-clk pulse on entry to GAME.

Behaviour:
- Reset is sampled only on the clk rising edge with rst==0. It forces: screen_sel=0, cursor_idx=0, cursor_vis=0, difficulty=1, game_start=0, all debounce counters=0, all stable levels=0, blink counter=0. Reset asserted mid-debounce or mid-blink discards all progress.
- Synchronisation: each button and vs passes through a 2-FF synchroniser.
- Debounce, per button:
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1, the stable level takes the synced level and the counter clears.
  - A bounce before that point restarts the count.
- Press event: a one-clk pulse on the 0->1 transition of a stable level. No auto-repeat.
- Event arbitration: at most one event is consumed per clk. Priority is sel > back > up > down. Lower-priority events in the same clk are dropped, not queued.
- State machine (state encoded directly in screen_sel, registered; outputs change one clk after the consuming event):
  - TITLE: sel -> MENU with cursor_idx=0. All other events are ignored.
  - MENU, up: cursor_idx-1; wraps from 0 to MENU_ITEMS-1.
  - MENU, down: cursor_idx+1; wraps from MENU_ITEMS-1 to 0.
  - MENU, sel at row 0 -> GAME; game_start=1 for exactly that one clk.
  - MENU, sel at row 1: difficulty steps 0->1->2->0; state stays MENU.
  - MENU, sel at row 2 -> CREDITS.
  - MENU, back -> TITLE.
  - GAME: game_over==1 -> TITLE with cursor_idx=0; difficulty is retained. All button events are ignored.
  - CREDITS: sel or back -> MENU; cursor_idx is unchanged (stays 2).
  - game_over is ignored outside GAME.
- Blink:
  - A frame tick is the falling edge of the synced vs.
  - In MENU, the blink counter counts frame ticks. At BLINK_FRAMES-1 it clears and cursor_vis toggles.
  - Any cursor move, and entry to MENU, forces cursor_vis=1 and clears the blink counter in the same clk.
  - Outside MENU: cursor_vis=0 and the counter is held at 0.
- Widths: cursor_idx and difficulty never take value 3. Debounce counter width is clog2(DB_CYCLES). Blink counter width is clog2(BLINK_FRAMES).

Test Plan:
- Reset, debounce and wrap (DB_CYCLES=4, BLINK_FRAMES=2 for all cases):
  - Hold rst=0 for 3 clk -> screen_sel=0, cursor_idx=0, cursor_vis=0, difficulty=1, game_start=0.
  - Then sel high for 10 clk -> screen_sel=1, cursor_vis=1.
  - Then up once -> cursor_idx=2 (wrap).
  - Then down twice -> cursor_idx=1.
- Bounce rejection: in MENU, toggle btn_down every 2 clk for 20 clk, then hold low -> no event, cursor_idx unchanged.
  - Then hold high for 6 clk -> exactly one step.
- Difficulty and start:
  - At row 1, press sel 3 times -> difficulty 2, 0, 1.
  - At row 0, press sel -> screen_sel=2 and game_start high for exactly 1 clk.
  - Press up in GAME -> no change.
  - Assert game_over -> screen_sel=0, cursor_idx=0, difficulty=1.
- Simultaneous events: in MENU at row 2, raise sel and back in the same clk -> CREDITS entered (sel wins).
  - Release and press back -> MENU with cursor_idx=2.
  - Raise up and down together -> cursor_idx=1.
- Blink: in MENU, drive 5 vs low pulses -> cursor_vis toggles after the 2nd and 4th (1,1,0,0,1).
  - A down press mid-sequence forces cursor_vis=1 and restarts the count.
  - Enter CREDITS -> cursor_vis=0.
- Reset mid-operation: assert rst=0 while in GAME with btn_sel held -> all reset values.
  - Release rst with btn_sel still held -> no press event (stable level re-qualifies from 0, then takes 1), state goes to MENU only after a fresh 0->1 transition.
